// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for the five-stage RV32 core: load-use and
// redirect detection, EX forwarding selects, data-memory wait freeze, event counters.
module pipe_hazard_ctrl #(
   parameter int WAIT_LIMIT = 16,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_useRs1,
   input  logic             id_useRs2,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_writeReg,
   input  logic [2:0]       ex_readMem,
   input  logic             ex_redirect,
   input  logic [4:0]       mem_rd,
   input  logic [4:0]       wb_rd,
   input  logic             mem_writeReg,
   input  logic             wb_writeReg,
   input  logic             mem_access,
   input  logic             dmem_ready,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             id_ex_stall,
   output logic             ex_mem_stall,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_bubble,
   output logic [1:0]       fwd_rs1_sel,
   output logic [1:0]       fwd_rs2_sel,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);

   typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

   state_t            r_state, w_state_nxt;
   logic [WCNT_W-1:0] r_wait, w_wait_nxt;
   logic              r_timeout;
   logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
   logic              w_freeze, w_load_use, w_redirect;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (mem_writeReg && mem_rd != 5'd0 && mem_rd == rs)
         return 2'b01;
      else if (wb_writeReg && wb_rd != 5'd0 && wb_rd == rs)
         return 2'b10;
      else
         return 2'b00;
   endfunction

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait;
      w_freeze    = 1'b0;
      case (r_state)
         S_RUN: begin
            if (mem_access && !dmem_ready) begin
               w_freeze    = 1'b1;
               w_state_nxt = S_WAIT;
               w_wait_nxt  = WCNT_W'(1);
            end
         end
         S_WAIT: begin
            if (dmem_ready) begin
               w_state_nxt = S_RUN;
               w_wait_nxt  = '0;
            end else begin
               w_freeze = 1'b1;
               if (r_wait == WCNT_W'(WAIT_LIMIT))
                  w_state_nxt = S_ERR;
               else
                  w_wait_nxt = r_wait + WCNT_W'(1);
            end
         end
         S_ERR: begin
            w_freeze = !dmem_ready;
         end
         default: begin
            w_state_nxt = S_RUN;
            w_wait_nxt  = '0;
         end
      endcase
   end

   // A redirect squashes the ID instruction, so its load-use hazard is moot;
   // a freeze holds EX, so both are deferred until the access completes.
   always_comb begin
      w_redirect = ex_redirect && !w_freeze;
      w_load_use = (ex_readMem != 3'd0) && ex_writeReg && (ex_rd != 5'd0) &&
                   ((id_useRs1 && ex_rd == id_rs1) || (id_useRs2 && ex_rd == id_rs2)) &&
                   !ex_redirect && !w_freeze;
   end

   always_comb begin
      pc_stall      = rst && (w_freeze || w_load_use);
      if_id_stall   = rst && (w_freeze || w_load_use);
      id_ex_stall   = rst && w_freeze;
      ex_mem_stall  = rst && w_freeze;
      mem_wb_bubble = rst && w_freeze;
      if_id_flush   = rst && w_redirect;
      id_ex_flush   = rst && (w_redirect || w_load_use);
      fwd_rs1_sel   = rst ? fwd_sel(ex_rs1) : 2'b00;
      fwd_rs2_sel   = rst ? fwd_sel(ex_rs2) : 2'b00;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_RUN;
         r_wait    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_wait  <= w_wait_nxt;
         if (w_state_nxt == S_ERR)
            r_timeout <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (pc_stall && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if ((if_id_flush || id_ex_flush) && r_flush_cnt != '1)
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign mem_timeout = r_timeout;
   assign stall_cnt   = r_stall_cnt;
   assign flush_cnt   = r_flush_cnt;

endmodule
